// File: rtl/uc_pkg.sv
// Shared types and constants for the microc control unit: opcode classes,
// FSM state encoding, error codes and the control-word layout.
package uc_pkg;

    typedef enum logic [2:0] {
        OPC_NOP,
        OPC_ALU,
        OPC_LI,
        OPC_J,
        OPC_JZ,
        OPC_JNZ,
        OPC_JAL,
        OPC_RET
    } opc_class_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_OVF  = 2'b01,
        ERR_UNF  = 2'b10
    } err_e;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic       s_rre;
        logic       s_ret;
        logic [2:0] op;
    } ctrl_t;

    // Control word presented while halted: PC frozen, nothing written.
    localparam ctrl_t CTRL_OFF = '0;

    localparam logic [2:0] ALU_PASS = 3'b000;

endpackage

// File: rtl/uc_decoder.sv
// Purely combinational opcode/zero-flag decode into the datapath control
// word, plus the opcode class used by the call-depth tracking in the FSM.
module uc_decoder
    import uc_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic        z,
    output ctrl_t       ctrl,
    output opc_class_e  opc_class
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        ctrl       = CTRL_OFF;
        ctrl.s_inc = 1'b1;
        opc_class  = OPC_NOP;

        // Unknown opcode bits match no item and fall through to nop.
        casez (opcode[5:2])
            4'b0???: begin
                opc_class = OPC_ALU;
                ctrl.op   = opcode[4:2];
                ctrl.we3  = 1'b1;
                ctrl.wez  = 1'b1;
            end
            4'b1000: begin
                opc_class  = OPC_LI;
                ctrl.s_inm = 1'b1;
                ctrl.we3   = 1'b1;
                ctrl.op    = ALU_PASS;
            end
            4'b1001: begin
                opc_class  = OPC_J;
                ctrl.s_inc = 1'b0;
            end
            4'b1010: begin
                opc_class  = OPC_JZ;
                ctrl.s_inc = ~z;
            end
            4'b1011: begin
                opc_class  = OPC_JNZ;
                ctrl.s_inc = z;
            end
            4'b1100: begin
                opc_class  = OPC_JAL;
                ctrl.s_inc = 1'b0;
                ctrl.s_rre = 1'b1;
            end
            4'b1101: begin
                opc_class  = OPC_RET;
                ctrl.s_inc = 1'b0;
                ctrl.s_ret = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/uc_control_fsm.sv
// microc control unit: combinational control word, call-depth tracking with
// sticky ERROR/halt. Optional perf counters built when UC_PERF_EN is defined.
module uc_control_fsm
    import uc_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               z,
    output logic               s_inc,
    output logic               s_inm,
    output logic               we3,
    output logic               wez,
    output logic               s_rre,
    output logic               s_ret,
    output logic [2:0]         op,
    output logic               halt,
    output logic [1:0]         error,
    output logic [DEPTH_W-1:0] depth,
    output logic [15:0]        instr_cnt,
    output logic [15:0]        jump_cnt
);

    ctrl_t        dec_ctrl;
    ctrl_t        out_ctrl;
    opc_class_e   opc_class;

    state_e             state_q, state_d;
    err_e               err_q, err_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               fault;
    logic               halt_c;

    uc_decoder u_decoder (
        .opcode    (opcode),
        .z         (z),
        .ctrl      (dec_ctrl),
        .opc_class (opc_class)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        depth_d  = depth_q;
        fault    = 1'b0;
        halt_c   = 1'b0;
        out_ctrl = dec_ctrl;

        case (state_q)
            ST_RUN: begin
                if (opc_class == OPC_JAL && depth_q == DEPTH_W'(STACK_DEPTH)) begin
                    fault = 1'b1;
                    err_d = ERR_OVF;
                end else if (opc_class == OPC_RET && depth_q == '0) begin
                    fault = 1'b1;
                    err_d = ERR_UNF;
                end else if (opc_class == OPC_JAL) begin
                    depth_d = depth_q + DEPTH_W'(1);
                end else if (opc_class == OPC_RET) begin
                    depth_d = depth_q - DEPTH_W'(1);
                end

                // The offending instruction never reaches the datapath.
                if (fault) begin
                    state_d  = ST_ERROR;
                    out_ctrl = CTRL_OFF;
                    halt_c   = 1'b1;
                end
            end
            default: begin
                out_ctrl = CTRL_OFF;
                halt_c   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            err_q   <= ERR_NONE;
            depth_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values
            // computed above, independent of statement order.
            state_q <= state_d;
            err_q   <= err_d;
            depth_q <= depth_d;
        end
    end

    assign s_inc = out_ctrl.s_inc;
    assign s_inm = out_ctrl.s_inm;
    assign we3   = out_ctrl.we3;
    assign wez   = out_ctrl.wez;
    assign s_rre = out_ctrl.s_rre;
    assign s_ret = out_ctrl.s_ret;
    assign op    = out_ctrl.op;
    assign halt  = halt_c;
    assign error = err_q;
    assign depth = depth_q;

`ifdef UC_PERF_EN
    logic [15:0] instr_q;
    logic [15:0] jump_q;
    logic        retire;

    assign retire = (state_q == ST_RUN) && !fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            jump_q  <= '0;
        end else if (retire) begin
            instr_q <= instr_q + 16'd1;
            if (!dec_ctrl.s_inc) begin
                jump_q <= jump_q + 16'd1;
            end
        end
    end

    assign instr_cnt = instr_q;
    assign jump_cnt  = jump_q;
`else
    assign instr_cnt = '0;
    assign jump_cnt  = '0;
`endif

endmodule
